// File: rtl/obi_sram_shim.sv
// -----------------------------------------------------------------------------
// obi_sram_shim
//
// OBI subordinate that terminates a single OBI manager port and drives one
// single-port SRAM macro. Every cycle it grants and accepts one request. The
// SRAM is driven combinationally in the accept cycle. The response comes back
// exactly Latency cycles later through a metadata pipeline, so there is never
// any backpressure.
//
// Extras on top of a plain SRAM port:
//   - address-window check (out-of-window accesses return err=1)
//   - aid -> rid echo
//   - LR/SC exclusive access through a single reservation register
//   - any other atomic (AMO*) returns err=1
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   obi_req_i     OBI request  (req, a.addr/we/be/wdata/aid/a_optional.atop)
//   obi_rsp_o     OBI response (gnt, rvalid, r.rdata/rid/err/r_optional.exokay)
//   sram_req_o    SRAM access enable
//   sram_we_o     SRAM write enable
//   sram_addr_o   SRAM word address
//   sram_wdata_o  SRAM write data
//   sram_be_o     SRAM byte enables
//   sram_rdata_i  SRAM read data, valid Latency cycles after sram_req_o
// -----------------------------------------------------------------------------

package obi_pkg;

    typedef logic [5:0] atop_t;

    localparam atop_t ATOPNONE = 6'h00;
    localparam atop_t AMOADD   = 6'h20;
    localparam atop_t AMOSWAP  = 6'h21;
    localparam atop_t ATOPLR   = 6'h22;
    localparam atop_t ATOPSC   = 6'h23;
    localparam atop_t AMOXOR   = 6'h24;
    localparam atop_t AMOOR    = 6'h28;
    localparam atop_t AMOAND   = 6'h2C;
    localparam atop_t AMOMIN   = 6'h30;
    localparam atop_t AMOMAX   = 6'h34;
    localparam atop_t AMOMINU  = 6'h38;
    localparam atop_t AMOMAXU  = 6'h3C;

    typedef struct packed {
        bit UseAtop;
    } obi_optional_cfg_t;

    typedef struct packed {
        int unsigned       AddrWidth;
        int unsigned       DataWidth;
        int unsigned       IdWidth;
        obi_optional_cfg_t OptionalCfg;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth:   32,
        DataWidth:   32,
        IdWidth:     1,
        OptionalCfg: '{UseAtop: 1'b0}
    };

    // Request/response types matching ObiDefaultConfig.
    typedef struct packed {
        atop_t atop;
    } obi_default_a_optional_t;

    typedef struct packed {
        logic [31:0]             addr;
        logic                    we;
        logic [3:0]              be;
        logic [31:0]             wdata;
        logic [0:0]              aid;
        obi_default_a_optional_t a_optional;
    } obi_default_a_chan_t;

    typedef struct packed {
        obi_default_a_chan_t a;
        logic                req;
    } obi_default_req_t;

    typedef struct packed {
        logic exokay;
    } obi_default_r_optional_t;

    typedef struct packed {
        logic [31:0]             rdata;
        logic [0:0]              rid;
        logic                    err;
        obi_default_r_optional_t r_optional;
    } obi_default_r_chan_t;

    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        obi_default_r_chan_t r;
    } obi_default_rsp_t;

endpackage

module obi_sram_shim #(
    parameter obi_pkg::obi_cfg_t            ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type                          obi_req_t = obi_pkg::obi_default_req_t,
    parameter type                          obi_rsp_t = obi_pkg::obi_default_rsp_t,
    parameter logic [ObiCfg.AddrWidth-1:0]  BaseAddr  = '0,
    parameter int unsigned                  NumWords  = 1024,
    parameter int unsigned                  Latency   = 1,
    parameter int unsigned                  AddrW     = $clog2(NumWords)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  obi_req_t                        obi_req_i,
    output obi_rsp_t                        obi_rsp_o,
    output logic                            sram_req_o,
    output logic                            sram_we_o,
    output logic [AddrW-1:0]                sram_addr_o,
    output logic [ObiCfg.DataWidth-1:0]     sram_wdata_o,
    output logic [ObiCfg.DataWidth/8-1:0]   sram_be_o,
    input  logic [ObiCfg.DataWidth-1:0]     sram_rdata_i
);

    localparam int unsigned AW       = ObiCfg.AddrWidth;
    localparam int unsigned DW       = ObiCfg.DataWidth;
    localparam int unsigned IW       = ObiCfg.IdWidth;
    localparam int unsigned BeW      = DW / 8;
    localparam int unsigned ByteOffW = $clog2(BeW);
    localparam int unsigned WinBytes = NumWords * BeW;

    // One extra bit so a window that ends exactly at the top of the address
    // space does not wrap to zero.
    localparam logic [AW:0] WinLo = {1'b0, BaseAddr};
    localparam logic [AW:0] WinHi = WinLo + (AW+1)'(WinBytes);

    // Metadata travelling alongside the SRAM read. The override value is only
    // ever 0 or 1 (error / SC result), so a single bit is enough.
    typedef struct packed {
        logic          valid;
        logic [IW-1:0] aid;
        logic          err;
        logic          exokay;
        logic          ovr_en;
        logic          ovr_val;
    } stage_t;

    logic               accept;
    logic               in_range;
    logic [AddrW-1:0]   word_addr;
    obi_pkg::atop_t     atop;
    logic               resv_hit;

    logic               resv_valid_q, resv_valid_d;
    logic [AddrW-1:0]   resv_addr_q,  resv_addr_d;

    stage_t             stage_d;
    stage_t             stage_q [Latency];

    // gnt is simply "out of reset", so accept collapses to req while running.
    assign accept    = obi_req_i.req & rst_ni;
    assign in_range  = ({1'b0, obi_req_i.a.addr} >= WinLo) &&
                       ({1'b0, obi_req_i.a.addr} <  WinHi);
    assign word_addr = AddrW'((obi_req_i.a.addr - BaseAddr) >> ByteOffW);
    assign atop      = ObiCfg.OptionalCfg.UseAtop ? obi_req_i.a.a_optional.atop
                                                  : obi_pkg::ATOPNONE;
    // Uses the reservation registered before this cycle; updates land at t+1.
    assign resv_hit  = resv_valid_q && (resv_addr_q == word_addr);

    assign sram_addr_o  = word_addr;
    assign sram_wdata_o = obi_req_i.a.wdata;
    assign sram_be_o    = obi_req_i.a.be;

    // Request classification.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        //       leaves a signal unassigned, which would infer a latch.
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        stage_d      = '0;

        if (accept) begin
            stage_d.valid = 1'b1;
            stage_d.aid   = obi_req_i.a.aid;

            if (!in_range) begin
                // Out-of-window accesses never touch the reservation.
                stage_d.err    = 1'b1;
                stage_d.ovr_en = 1'b1;
            end else begin
                case (atop)
                    obi_pkg::ATOPNONE: begin
                        sram_req_o = 1'b1;
                        sram_we_o  = obi_req_i.a.we;
                        if (obi_req_i.a.we && resv_hit) begin
                            resv_valid_d = 1'b0;
                        end
                    end
                    obi_pkg::ATOPLR: begin
                        sram_req_o     = 1'b1;
                        resv_valid_d   = 1'b1;
                        resv_addr_d    = word_addr;
                        stage_d.exokay = 1'b1;
                    end
                    obi_pkg::ATOPSC: begin
                        // Success or failure, an SC consumes the reservation.
                        resv_valid_d   = 1'b0;
                        stage_d.ovr_en = 1'b1;
                        if (resv_hit) begin
                            sram_req_o     = 1'b1;
                            sram_we_o      = 1'b1;
                            stage_d.exokay = 1'b1;
                        end else begin
                            stage_d.ovr_val = 1'b1;
                        end
                    end
                    default: begin
                        stage_d.err    = 1'b1;
                        stage_d.ovr_en = 1'b1;
                    end
                endcase
            end
        end
    end

    // Reservation and response pipeline.
    // NOTE: the pipeline is small control state, so every stage is reset; this
    //       is what discards in-flight responses on reset. The SRAM contents
    //       themselves are never reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            for (int i = 0; i < int'(Latency); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so each stage shifts the value it
            //       held before this edge, not one already updated this edge.
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            stage_q[0]   <= stage_d;
            for (int i = 1; i < int'(Latency); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Response. rdata is muxed live from the SRAM, which presents its data in
    // the same cycle the last stage becomes visible.
    always_comb begin
        obi_rsp_o                   = '0;
        obi_rsp_o.gnt               = rst_ni;
        obi_rsp_o.rvalid            = stage_q[Latency-1].valid;
        obi_rsp_o.r.rid             = stage_q[Latency-1].aid;
        obi_rsp_o.r.err             = stage_q[Latency-1].err;
        obi_rsp_o.r.r_optional.exokay = stage_q[Latency-1].exokay;
        if (!stage_q[Latency-1].valid) begin
            obi_rsp_o.r.rdata = '0;
        end else if (stage_q[Latency-1].ovr_en) begin
            obi_rsp_o.r.rdata = DW'(stage_q[Latency-1].ovr_val);
        end else begin
            obi_rsp_o.r.rdata = sram_rdata_i;
        end
    end

endmodule

// File: tb/tb_obi_sram_shim.sv
// -----------------------------------------------------------------------------
// tb_obi_sram_shim
//
// Two instances of obi_sram_shim, each with a small behavioural SRAM:
//   u_dut1: Latency=1, BaseAddr=0x1000, NumWords=1024 (table-driven vectors)
//   u_dut3: Latency=3, BaseAddr=0x0,    NumWords=16   (pipelining and reset)
// Inputs are driven on the falling edge. Responses are also sampled on the
// falling edge, and the combinational SRAM drive is sampled 1 time unit later.
// -----------------------------------------------------------------------------

module tb_obi_sram_shim;

    typedef struct packed { logic [5:0] atop; } a_opt_t;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
        a_opt_t      a_optional;
    } a_chan_t;
    typedef struct packed { a_chan_t a; logic req; } req_t;
    typedef struct packed { logic exokay; } r_opt_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        r_opt_t      r_optional;
    } r_chan_t;
    typedef struct packed { logic gnt; logic rvalid; r_chan_t r; } rsp_t;

    localparam obi_pkg::obi_cfg_t TbCfg = '{
        AddrWidth: 32, DataWidth: 32, IdWidth: 4, OptionalCfg: '{UseAtop: 1'b1}
    };

    logic clk = 1'b0;
    logic rst1_n, rst3_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;

    // ---------------- Latency=1 instance ----------------
    req_t        req1;
    rsp_t        rsp1;
    logic        s1_req, s1_we;
    logic [9:0]  s1_addr;
    logic [31:0] s1_wdata, s1_rdata;
    logic [3:0]  s1_be;
    logic [31:0] mem1 [1024];

    obi_sram_shim #(
        .ObiCfg(TbCfg), .obi_req_t(req_t), .obi_rsp_t(rsp_t),
        .BaseAddr(32'h1000), .NumWords(1024), .Latency(1)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .obi_req_i(req1), .obi_rsp_o(rsp1),
        .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr),
        .sram_wdata_o(s1_wdata), .sram_be_o(s1_be), .sram_rdata_i(s1_rdata)
    );

    always @(posedge clk) begin
        if (s1_req) begin
            if (s1_we) begin
                for (int b = 0; b < 4; b++)
                    if (s1_be[b]) mem1[s1_addr][8*b +: 8] <= s1_wdata[8*b +: 8];
            end
            s1_rdata <= mem1[s1_addr];
        end
    end

    // ---------------- Latency=3 instance ----------------
    req_t        req3;
    rsp_t        rsp3;
    logic        s3_req, s3_we;
    logic [3:0]  s3_addr;
    logic [31:0] s3_wdata, s3_p0, s3_p1, s3_p2;
    logic [3:0]  s3_be;
    logic [31:0] mem3 [16];

    obi_sram_shim #(
        .ObiCfg(TbCfg), .obi_req_t(req_t), .obi_rsp_t(rsp_t),
        .BaseAddr(32'h0), .NumWords(16), .Latency(3)
    ) u_dut3 (
        .clk_i(clk), .rst_ni(rst3_n), .obi_req_i(req3), .obi_rsp_o(rsp3),
        .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_addr_o(s3_addr),
        .sram_wdata_o(s3_wdata), .sram_be_o(s3_be), .sram_rdata_i(s3_p2)
    );

    always @(posedge clk) begin
        if (s3_req) begin
            if (s3_we) begin
                for (int b = 0; b < 4; b++)
                    if (s3_be[b]) mem3[s3_addr][8*b +: 8] <= s3_wdata[8*b +: 8];
            end
            s3_p0 <= mem3[s3_addr];
        end
        s3_p1 <= s3_p0;
        s3_p2 <= s3_p1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  aid;
        logic [5:0]  atop;
        logic        x_sreq;
        logic        x_swe;
        logic [9:0]  x_saddr;
        logic        x_rvalid;
        logic        x_err;
        logic        x_exok;
        logic        x_chk;
        logic [31:0] x_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic req, input logic [31:0] addr, input logic we,
        input logic [31:0] wdata, input logic [3:0] aid, input logic [5:0] atop,
        input logic x_sreq, input logic x_swe, input logic [9:0] x_saddr,
        input logic x_rvalid, input logic x_err, input logic x_exok,
        input logic x_chk, input logic [31:0] x_rdata);
        vec_t v;
        v.req = req; v.addr = addr; v.we = we; v.wdata = wdata; v.aid = aid;
        v.atop = atop; v.x_sreq = x_sreq; v.x_swe = x_swe; v.x_saddr = x_saddr;
        v.x_rvalid = x_rvalid; v.x_err = x_err; v.x_exok = x_exok;
        v.x_chk = x_chk; v.x_rdata = x_rdata;
        return v;
    endfunction

    task automatic drive1(input vec_t v);
        req1.req               = v.req;
        req1.a.addr            = v.addr;
        req1.a.we              = v.we;
        req1.a.be              = 4'hF;
        req1.a.wdata           = v.wdata;
        req1.a.aid             = v.aid;
        req1.a.a_optional.atop = v.atop;
    endtask

    task automatic check_sram1(input int i, input vec_t v);
        check($sformatf("v%0d sram_req", i), 32'(s1_req), 32'(v.x_sreq));
        if (v.x_sreq) begin
            check($sformatf("v%0d sram_we", i), 32'(s1_we), 32'(v.x_swe));
            check($sformatf("v%0d sram_addr", i), 32'(s1_addr), 32'(v.x_saddr));
            if (v.x_swe) check($sformatf("v%0d sram_wdata", i), s1_wdata, v.wdata);
        end
    endtask

    task automatic check_rsp1(input int i, input vec_t v);
        check($sformatf("v%0d rvalid", i), 32'(rsp1.rvalid), 32'(v.x_rvalid));
        if (v.x_rvalid) begin
            check($sformatf("v%0d rid", i), 32'(rsp1.r.rid), 32'(v.aid));
            check($sformatf("v%0d err", i), 32'(rsp1.r.err), 32'(v.x_err));
            check($sformatf("v%0d exokay", i), 32'(rsp1.r.r_optional.exokay), 32'(v.x_exok));
            if (v.x_chk) check($sformatf("v%0d rdata", i), rsp1.r.rdata, v.x_rdata);
        end
    endtask

    task automatic drive3(input logic req, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] aid,
                          input logic [5:0] atop);
        req3.req               = req;
        req3.a.addr            = addr;
        req3.a.we              = we;
        req3.a.be              = 4'hF;
        req3.a.wdata           = wdata;
        req3.a.aid             = aid;
        req3.a.a_optional.atop = atop;
    endtask

    localparam logic [5:0] NONE = obi_pkg::ATOPNONE;
    localparam logic [5:0] LR   = obi_pkg::ATOPLR;
    localparam logic [5:0] SC   = obi_pkg::ATOPSC;
    localparam logic [5:0] ADD  = obi_pkg::AMOADD;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req addr          we wdata         aid atop  sreq swe saddr  rv err exo chk rdata
        vecs[0]  = mk(1, 32'h1008,     1, 32'hDEADBEEF, 3,  NONE, 1,   1,  10'd2, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h1008,     0, 32'h0,        5,  NONE, 1,   0,  10'd2, 1, 0, 0, 1, 32'hDEADBEEF);
        vecs[2]  = mk(1, 32'h0FFC,     0, 32'h0,        1,  NONE, 0,   0,  10'd0, 1, 1, 0, 1, 0);
        vecs[3]  = mk(1, 32'h2000,     0, 32'h0,        2,  NONE, 0,   0,  10'd0, 1, 1, 0, 1, 0);
        vecs[4]  = mk(1, 32'h1FFC,     0, 32'h0,        3,  NONE, 1,   0,  10'd1023, 1, 0, 0, 0, 0);
        vecs[5]  = mk(1, 32'h1010,     0, 32'h0,        4,  LR,   1,   0,  10'd4, 1, 0, 1, 0, 0);
        vecs[6]  = mk(1, 32'h1010,     0, 32'h55,       6,  SC,   1,   1,  10'd4, 1, 0, 1, 1, 0);
        vecs[7]  = mk(1, 32'h1010,     0, 32'h66,       7,  SC,   0,   0,  10'd0, 1, 0, 0, 1, 1);
        vecs[8]  = mk(1, 32'h1010,     0, 32'h0,        8,  NONE, 1,   0,  10'd4, 1, 0, 0, 1, 32'h55);
        vecs[9]  = mk(1, 32'h1010,     0, 32'h0,        9,  LR,   1,   0,  10'd4, 1, 0, 1, 1, 32'h55);
        vecs[10] = mk(1, 32'h1010,     1, 32'h77,       10, NONE, 1,   1,  10'd4, 1, 0, 0, 0, 0);
        vecs[11] = mk(1, 32'h1010,     0, 32'h99,       11, SC,   0,   0,  10'd0, 1, 0, 0, 1, 1);
        vecs[12] = mk(1, 32'h1010,     0, 32'h0,        12, LR,   1,   0,  10'd4, 1, 0, 1, 1, 32'h77);
        vecs[13] = mk(1, 32'h1014,     1, 32'h11,       13, NONE, 1,   1,  10'd5, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 32'h1010,     0, 32'hAB,       14, SC,   1,   1,  10'd4, 1, 0, 1, 1, 0);
        vecs[15] = mk(1, 32'h1010,     0, 32'h0,        15, NONE, 1,   0,  10'd4, 1, 0, 0, 1, 32'hAB);
        vecs[16] = mk(1, 32'h1010,     0, 32'h0,        2,  ADD,  0,   0,  10'd0, 1, 1, 0, 1, 0);
        vecs[17] = mk(0, 32'h0,        0, 32'h0,        0,  NONE, 0,   0,  10'd0, 0, 0, 0, 0, 0);

        rst1_n = 1'b0;
        rst3_n = 1'b0;
        req1   = '0;
        req3   = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst rvalid", 32'(rsp1.rvalid), 0);
        check("rst rid", 32'(rsp1.r.rid), 0);
        check("rst err", 32'(rsp1.r.err), 0);
        check("rst exokay", 32'(rsp1.r.r_optional.exokay), 0);
        check("rst rdata", rsp1.r.rdata, 0);
        check("rst3 rvalid", 32'(rsp3.rvalid), 0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        check("gnt out of reset", 32'(rsp1.gnt), 1);

        // Latency=1 table: the response of each row is checked on the next row.
        for (int i = 0; i < NV; i++) begin
            if (i > 0) check_rsp1(i - 1, vecs[i - 1]);
            drive1(vecs[i]);
            #1 check_sram1(i, vecs[i]);
            @(negedge clk);
        end
        check_rsp1(NV - 1, vecs[NV - 1]);

        // Latency=3: eight back-to-back reads, rvalid from the third cycle on.
        for (int j = 0; j < 12; j++) begin
            check($sformatf("l3 rvalid c%0d", j), 32'(rsp3.rvalid), 32'((j >= 3) && (j < 11)));
            if ((j >= 3) && (j < 11)) check($sformatf("l3 rid c%0d", j), 32'(rsp3.r.rid), 32'(j - 3));
            if (j < 8) drive3(1, 32'(j * 4), 0, 0, 4'(j), NONE);
            else       drive3(0, 0, 0, 0, 0, NONE);
            @(negedge clk);
        end

        // Latency=3: LR plus three reads in flight, then reset mid-operation.
        drive3(1, 32'h8, 0, 0, 9, LR);
        @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            if (j == 3) begin
                check("l3 lr rvalid", 32'(rsp3.rvalid), 1);
                check("l3 lr rid", 32'(rsp3.r.rid), 9);
                check("l3 lr exokay", 32'(rsp3.r.r_optional.exokay), 1);
            end
            if (j == 4) check("l3 rd1 rid", 32'(rsp3.r.rid), 1);
            drive3(1, 32'h0, 0, 0, 4'(j), NONE);
            @(negedge clk);
        end
        check("l3 rd2 rid", 32'(rsp3.r.rid), 2);
        drive3(0, 0, 0, 0, 0, NONE);
        rst3_n = 1'b0;
        #1 check("l3 rvalid at reset", 32'(rsp3.rvalid), 0);
        @(negedge clk);
        check("l3 rvalid in reset", 32'(rsp3.rvalid), 0);
        rst3_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("l3 no rsp after reset c%0d", j), 32'(rsp3.rvalid), 0);
        end

        // Reservation was dropped by reset: SC must fail.
        drive3(1, 32'h8, 0, 32'h5, 6, SC);
        #1 check("l3 sc sram_req", 32'(s3_req), 0);
        @(negedge clk);
        drive3(0, 0, 0, 0, 0, NONE);
        repeat (2) @(negedge clk);
        check("l3 sc rvalid", 32'(rsp3.rvalid), 1);
        check("l3 sc rid", 32'(rsp3.r.rid), 6);
        check("l3 sc rdata", rsp3.r.rdata, 1);
        check("l3 sc exokay", 32'(rsp3.r.r_optional.exokay), 0);
        check("l3 sc err", 32'(rsp3.r.err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
